hsst_rst_seq_gen_v1_0: RTL

//  Reset sequencer for one HSST/PIPE lane. Drives pll_rst, tx_rst and rx_rst in the required order.

---
 rtl/hsst_rst_seq_pkg.sv | 18 +
 rtl/hsst_rst_seq_tmr_v1_0.sv | 30 +++
 rtl/hsst_rst_seq_gen_v1_0.sv | 138 +++++++++++++
 3 files changed

// File: rtl/hsst_rst_seq_pkg.sv
// Shared types for the HSST lane reset sequencer.
// Sequencer phase encoding and retry counter width.
package hsst_rst_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        TX_DLY    = 3'd2,
        WAIT_CDR  = 3'd3,
        RX_DLY    = 3'd4,
        DONE      = 3'd5
    } seq_state_t;

    localparam int RETRY_W = 4;
    localparam logic [RETRY_W-1:0] RETRY_MAX = '1;
    localparam logic [RETRY_W-1:0] RETRY_ONE = {{(RETRY_W-1){1'b0}}, 1'b1};

endpackage

// File: rtl/hsst_rst_seq_tmr_v1_0.sv
// Clearable saturating phase/timeout counter with terminal compare.
// Shared by every timed phase of the reset sequencer.
module hsst_rst_seq_tmr_v1_0
    import hsst_rst_seq_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         hit
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + ONE;
        end
    end

    assign hit = (cnt == term);

endmodule

// File: rtl/hsst_rst_seq_gen_v1_0.sv
// HSST/PIPE lane reset sequencer: orders pll_rst, tx_rst, rx_rst.
// Optional WAIT_LOCK/WAIT_CDR timeout enabled by HSST_RST_TIMEOUT_EN.
module hsst_rst_seq_gen_v1_0
    import hsst_rst_seq_pkg::*;
#(
    parameter int                    CNTR_WIDTH     = 16,
    parameter logic [CNTR_WIDTH-1:0] PLL_RST_CYCLES = 16'd64,
    parameter logic [CNTR_WIDTH-1:0] TX_DLY_CYCLES  = 16'd32,
    parameter logic [CNTR_WIDTH-1:0] RX_DLY_CYCLES  = 16'd32,
    parameter logic [CNTR_WIDTH-1:0] TIMEOUT_CYCLES = 16'hFFFF,
    parameter logic                  ACTIVE_HIGH    = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rst_req,
    input  logic               pll_lock_deb,
    input  logic               cdr_rdy_deb,
    output logic               pll_rst,
    output logic               tx_rst,
    output logic               rx_rst,
    output logic               rst_done,
    output logic               timeout_err,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam logic [CNTR_WIDTH-1:0] ONE = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

    seq_state_t            state;
    seq_state_t            nxt;
    logic [CNTR_WIDTH-1:0] cnt;
    logic [CNTR_WIDTH-1:0] term;
    logic                  hit;
    logic                  clr;
    logic                  lock_loss;
    logic                  tmo;
    logic                  pll_q;
    logic                  tx_q;
    logic                  rx_q;
    logic                  done_q;

    hsst_rst_seq_tmr_v1_0 #(
        .W(CNTR_WIDTH)
    ) u_tmr (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .term (term),
        .cnt  (cnt),
        .hit  (hit)
    );

    // Terminal count is phase length minus one: cnt starts at 0 on entry.
    always_comb begin
        term = TIMEOUT_CYCLES - ONE;
        case (state)
            PLL_RST: term = PLL_RST_CYCLES - ONE;
            TX_DLY:  term = TX_DLY_CYCLES - ONE;
            RX_DLY:  term = RX_DLY_CYCLES - ONE;
            default: term = TIMEOUT_CYCLES - ONE;
        endcase
    end

    assign lock_loss = !pll_lock_deb &&
                       (state == TX_DLY || state == WAIT_CDR ||
                        state == RX_DLY || state == DONE);

`ifdef HSST_RST_TIMEOUT_EN
    logic               terr_q;
    logic [RETRY_W-1:0] retry_q;

    assign tmo = hit && !rst_req && !lock_loss &&
                 (state == WAIT_LOCK || state == WAIT_CDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            terr_q  <= 1'b0;
            retry_q <= '0;
        end else begin
            terr_q <= tmo;
            if (tmo && retry_q != RETRY_MAX) begin
                retry_q <= retry_q + RETRY_ONE;
            end
        end
    end

    assign timeout_err = terr_q;
    assign retry_cnt   = retry_q;
`else
    assign tmo         = 1'b0;
    assign timeout_err = 1'b0;
    assign retry_cnt   = '0;
`endif

    always_comb begin
        nxt = state;
        if (rst_req || lock_loss || tmo) begin
            nxt = PLL_RST;
        end else begin
            case (state)
                PLL_RST:   if (hit) nxt = WAIT_LOCK;
                WAIT_LOCK: if (pll_lock_deb) nxt = TX_DLY;
                TX_DLY:    if (hit) nxt = WAIT_CDR;
                WAIT_CDR:  if (cdr_rdy_deb) nxt = RX_DLY;
                RX_DLY: begin
                    if (!cdr_rdy_deb) nxt = WAIT_CDR;
                    else if (hit)     nxt = DONE;
                end
                DONE:      if (!cdr_rdy_deb) nxt = WAIT_CDR;
                default:   nxt = PLL_RST;
            endcase
        end
    end

    // A held rst_req re-enters PLL_RST each cycle, so cnt must clear too.
    assign clr = rst_req || (nxt != state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= PLL_RST;
            pll_q  <= 1'b1;
            tx_q   <= 1'b1;
            rx_q   <= 1'b1;
            done_q <= 1'b0;
        end else begin
            state  <= nxt;
            pll_q  <= (nxt == PLL_RST);
            tx_q   <= (nxt == PLL_RST || nxt == WAIT_LOCK || nxt == TX_DLY);
            rx_q   <= (nxt != DONE);
            done_q <= (nxt == DONE);
        end
    end

    assign pll_rst  = ACTIVE_HIGH ? pll_q : ~pll_q;
    assign tx_rst   = ACTIVE_HIGH ? tx_q : ~tx_q;
    assign rx_rst   = ACTIVE_HIGH ? rx_q : ~rx_q;
    assign rst_done = done_q;

endmodule
